regbank_ctrl: RTL and testbench

- Write-port controller for the 32x32 datapath register bank.
- After reset it clears every register with a hardware sweep, so the bank no longer depends on a simulation-only preload.
- It then shares the bank's single write port between the core writeback path and a debug/loader port.
- Core has priority; a starvation limit guarantees loader progress. Sits between writeback, loader and the bank.

---
 rtl/regbank_pkg.sv | 19 +
 rtl/regbank_init_seq.sv | 32 +++
 rtl/regbank_ctrl.sv | 113 +++++++++++
 tb/tb_regbank_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// Shared constants and types for the register-bank write-port controller.
package regbank_pkg;

    localparam int unsigned NREGS = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 32;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wreq_t;

endpackage

// File: rtl/regbank_init_seq.sv
// Post-reset clearing sweep: walks every bank address once while enabled.
module regbank_init_seq
    import regbank_pkg::*;
#(
    parameter logic [DW-1:0] INIT_VALUE = '0
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    output wreq_t req_c,
    output logic  done_c
);

    logic [AW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + AW'(1);
        end
    end

    // done_c marks the cycle whose write is the final address of the sweep
    always_comb begin
        req_c.we   = en;
        req_c.addr = cnt;
        req_c.data = INIT_VALUE;
        done_c     = en && (cnt == AW'(NREGS - 1));
    end

endmodule

// File: rtl/regbank_ctrl.sv
// Register-bank write-port controller: clears the bank after reset, then
// arbitrates the single write port between core writeback and the loader.
module regbank_ctrl
    import regbank_pkg::*;
#(
    parameter logic [DW-1:0] INIT_VALUE   = 32'h0000_0000,
    parameter int unsigned   STARVE_LIMIT = 4,
    parameter bit            ZERO_PROTECT = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          core_we,
    input  logic [AW-1:0] core_waddr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_stall,
    input  logic          dbg_valid,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_data,
    output logic          dbg_ready,
    output logic          bank_we,
    output logic [AW-1:0] bank_waddr,
    output logic [DW-1:0] bank_wdata,
    output logic          init_done
);

    localparam int unsigned WCW = ($clog2(STARVE_LIMIT + 1) > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    state_e         state;
    logic [WCW-1:0] wait_cnt;
    wreq_t          init_req;
    wreq_t          win;
    logic           init_last;
    logic           starved;
    logic           gnt_dbg;
    logic           gnt_core;
    logic           blocked;

    regbank_init_seq #(
        .INIT_VALUE (INIT_VALUE)
    ) u_init_seq (
        .clk    (clk),
        .rst    (rst),
        .en     (state == ST_INIT),
        .req_c  (init_req),
        .done_c (init_last)
    );

    assign starved = (wait_cnt == WCW'(STARVE_LIMIT));

    // Same-cycle grant; the core wins unless the loader has waited long enough
    always_comb begin
        gnt_dbg    = 1'b0;
        gnt_core   = 1'b0;
        core_stall = 1'b1;
        dbg_ready  = 1'b0;
        if (!rst) begin
            if (state == ST_INIT) begin
                core_stall = core_we;
            end else begin
                gnt_dbg    = dbg_valid & (~core_we | starved);
                gnt_core   = core_we & ~gnt_dbg;
                dbg_ready  = gnt_dbg;
                core_stall = core_we & gnt_dbg;
            end
        end
    end

    always_comb begin
        win.we   = gnt_dbg | gnt_core;
        win.addr = gnt_dbg ? dbg_addr : core_waddr;
        win.data = gnt_dbg ? dbg_data : core_wdata;
        blocked  = ZERO_PROTECT && (win.addr == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_INIT;
            wait_cnt   <= '0;
            bank_we    <= 1'b0;
            bank_waddr <= '0;
            bank_wdata <= '0;
            init_done  <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    bank_we    <= init_req.we;
                    bank_waddr <= init_req.addr;
                    bank_wdata <= init_req.data;
                    if (init_last) begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                    end
                end
                default: begin
                    // Register-0 writes are acknowledged but never reach the bank
                    bank_we <= win.we & ~blocked;
                    if (win.we) begin
                        bank_waddr <= win.addr;
                        bank_wdata <= win.data;
                    end
                    if (dbg_valid && !gnt_dbg) begin
                        if (!starved) begin
                            wait_cnt <= wait_cnt + WCW'(1);
                        end
                    end else begin
                        wait_cnt <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regbank_ctrl.sv
// Scoreboard bench for regbank_ctrl: stimulus queues expected bank writes,
// a negedge monitor pops and compares them and checks the handshake outputs.
module tb_regbank_ctrl;
    import regbank_pkg::*;

    typedef struct {
        int unsigned   cyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          core_we;
    logic [AW-1:0] core_waddr;
    logic [DW-1:0] core_wdata;
    logic          core_stall;
    logic          dbg_valid;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_data;
    logic          dbg_ready;
    logic          bank_we;
    logic [AW-1:0] bank_waddr;
    logic [DW-1:0] bank_wdata;
    logic          init_done;

    int unsigned   n_cmp;
    int unsigned   n_err;
    int unsigned   cyc_n;
    exp_t          exp_q[$];
    exp_t          e;
    logic [DW-1:0] mem [NREGS];

    logic          chk_comb, chk_rst, chk_done, chk_mem, chk_drain;
    logic          exp_stall, exp_ready, exp_done;
    logic [AW-1:0] mem_idx;
    logic [DW-1:0] mem_exp;

    regbank_ctrl #(
        .INIT_VALUE   (32'h0000_0000),
        .STARVE_LIMIT (4),
        .ZERO_PROTECT (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .core_we    (core_we),
        .core_waddr (core_waddr),
        .core_wdata (core_wdata),
        .core_stall (core_stall),
        .dbg_valid  (dbg_valid),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data),
        .dbg_ready  (dbg_ready),
        .bank_we    (bank_we),
        .bank_waddr (bank_waddr),
        .bank_wdata (bank_wdata),
        .init_done  (init_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: bank writes against the queue, plus level checks armed by stimulus
    initial begin
        n_cmp = 0;
        n_err = 0;
        cyc_n = 0;
        for (int i = 0; i < NREGS; i++) mem[i] = 32'hA5A5_A5A5;
        forever begin
            @(negedge clk);
            cyc_n++;
            if (bank_we === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL bank_write: unexpected addr=%0d data=%h at cycle %0d",
                             bank_waddr, bank_wdata, cyc_n);
                end else begin
                    e = exp_q.pop_front();
                    if (bank_waddr !== e.addr || bank_wdata !== e.data || cyc_n != e.cyc) begin
                        n_err++;
                        $display("FAIL bank_write: got addr=%0d data=%h cyc=%0d, want addr=%0d data=%h cyc=%0d",
                                 bank_waddr, bank_wdata, cyc_n, e.addr, e.data, e.cyc);
                    end
                end
                mem[bank_waddr] = bank_wdata;
            end
            if (chk_comb) begin
                n_cmp++;
                if (core_stall !== exp_stall || dbg_ready !== exp_ready) begin
                    n_err++;
                    $display("FAIL handshake: cyc=%0d got stall=%b ready=%b, want stall=%b ready=%b",
                             cyc_n, core_stall, dbg_ready, exp_stall, exp_ready);
                end
            end
            if (chk_rst) begin
                n_cmp++;
                if (bank_we !== 1'b0 || bank_waddr !== '0 || bank_wdata !== '0) begin
                    n_err++;
                    $display("FAIL reset_outputs: cyc=%0d got we=%b addr=%0d data=%h, want 0/0/0",
                             cyc_n, bank_we, bank_waddr, bank_wdata);
                end
            end
            if (chk_done) begin
                n_cmp++;
                if (init_done !== exp_done) begin
                    n_err++;
                    $display("FAIL init_done: cyc=%0d got %b, want %b", cyc_n, init_done, exp_done);
                end
            end
            if (chk_mem) begin
                n_cmp++;
                if (mem[mem_idx] !== mem_exp) begin
                    n_err++;
                    $display("FAIL bank_model: reg%0d got %h, want %h", mem_idx, mem[mem_idx], mem_exp);
                end
            end
            if (chk_drain) begin
                n_cmp++;
                if (exp_q.size() != 0) begin
                    n_err++;
                    $display("FAIL drain: %0d expected writes never seen, want 0", exp_q.size());
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int unsigned c, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t x;
        x.cyc  = c;
        x.addr = a;
        x.data = d;
        exp_q.push_back(x);
    endtask

    task automatic comb(input logic s, input logic r);
        exp_stall = s;
        exp_ready = r;
        chk_comb  = 1'b1;
    endtask

    task automatic push_sweep();
        for (int i = 0; i < NREGS; i++) push(cyc_n + 1 + i, AW'(i), 32'h0000_0000);
    endtask

    task automatic mem_check(input logic [AW-1:0] idx, input logic [DW-1:0] v);
        mem_idx = idx;
        mem_exp = v;
        chk_mem = 1'b1;
        @(negedge clk);
        #1;
        chk_mem = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        core_we    = 1'b0;
        core_waddr = '0;
        core_wdata = '0;
        dbg_valid  = 1'b0;
        dbg_addr   = '0;
        dbg_data   = '0;
        chk_comb   = 1'b0;
        chk_rst    = 1'b0;
        chk_done   = 1'b0;
        chk_mem    = 1'b0;
        chk_drain  = 1'b0;
        exp_stall  = 1'b0;
        exp_ready  = 1'b0;
        exp_done   = 1'b0;
        mem_idx    = '0;
        mem_exp    = '0;

        // Reset state
        cyc();
        comb(1'b1, 1'b0);
        chk_rst  = 1'b1;
        exp_done = 1'b0;
        chk_done = 1'b1;
        @(negedge clk);
        #1;

        // Sweep: exactly NREGS writes of zero, then init_done
        chk_rst = 1'b0;
        push_sweep();
        rst = 1'b0;
        comb(1'b0, 1'b0);
        repeat (NREGS - 1) cyc();
        cyc();
        exp_done = 1'b1;
        cyc();

        // Plain core write
        core_we    = 1'b1;
        core_waddr = 5'd5;
        core_wdata = 32'hDEAD_BEEF;
        comb(1'b0, 1'b0);
        push(cyc_n + 2, 5'd5, 32'hDEAD_BEEF);
        cyc();
        core_we = 1'b0;
        cyc();

        // Loader starved by a continuous core stream, wins on the 5th cycle
        cyc();
        core_we    = 1'b1;
        core_waddr = 5'd3;
        core_wdata = 32'h0000_0033;
        dbg_valid  = 1'b1;
        dbg_addr   = 5'd7;
        dbg_data   = 32'h0000_1234;
        for (int k = 0; k < 4; k++) begin
            comb(1'b0, 1'b0);
            push(cyc_n + 2, 5'd3, 32'h0000_0033);
            cyc();
        end
        comb(1'b1, 1'b1);
        push(cyc_n + 2, 5'd7, 32'h0000_1234);
        cyc();
        dbg_valid = 1'b0;
        comb(1'b0, 1'b0);
        push(cyc_n + 2, 5'd3, 32'h0000_0033);
        cyc();
        core_we = 1'b0;
        comb(1'b0, 1'b0);
        cyc();

        // Register 0 is protected for both requesters
        dbg_valid = 1'b1;
        dbg_addr  = 5'd0;
        dbg_data  = 32'hFFFF_FFFF;
        comb(1'b0, 1'b1);
        cyc();
        dbg_valid  = 1'b0;
        core_we    = 1'b1;
        core_waddr = 5'd0;
        core_wdata = 32'h0000_CAFE;
        comb(1'b0, 1'b0);
        cyc();
        core_we = 1'b0;
        cyc();
        cyc();
        mem_check(5'd0,  32'h0000_0000);
        mem_check(5'd5,  32'hDEAD_BEEF);
        mem_check(5'd7,  32'h0000_1234);
        mem_check(5'd3,  32'h0000_0033);
        mem_check(5'd31, 32'h0000_0000);

        // Reset from RUN clears init_done before any clock edge
        cyc();
        rst       = 1'b1;
        dbg_valid = 1'b1;
        dbg_addr  = 5'd2;
        dbg_data  = 32'h0000_0022;
        comb(1'b1, 1'b0);
        chk_rst  = 1'b1;
        exp_done = 1'b0;
        @(negedge clk);
        #1;

        // Sweep aborted at count 10 by an asynchronous reset
        chk_rst = 1'b0;
        push_sweep();
        rst = 1'b0;
        comb(1'b0, 1'b0);
        repeat (10) cyc();
        rst        = 1'b1;
        core_we    = 1'b1;
        core_waddr = 5'd9;
        core_wdata = 32'h0000_0099;
        comb(1'b1, 1'b0);
        chk_rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        #1;

        // Full restarted sweep with a core write held throughout INIT
        chk_rst   = 1'b0;
        dbg_valid = 1'b0;
        push_sweep();
        rst = 1'b0;
        comb(1'b1, 1'b0);
        repeat (NREGS - 1) cyc();
        cyc();
        exp_done = 1'b1;
        comb(1'b0, 1'b0);
        push(cyc_n + 2, 5'd9, 32'h0000_0099);
        cyc();
        core_we = 1'b0;
        comb(1'b0, 1'b0);
        cyc();
        cyc();
        mem_check(5'd5, 32'h0000_0000);
        mem_check(5'd9, 32'h0000_0099);
        mem_check(5'd0, 32'h0000_0000);

        chk_drain = 1'b1;
        @(negedge clk);
        #1;
        chk_drain = 1'b0;
        chk_comb  = 1'b0;
        chk_done  = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
